// File: rtl/cla_multiword_seq_pkg.sv
// Shared types for the multi-word add/subtract sequencer: FSM state
// encoding and the sizing rule for the word index.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-word build still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_multiword_seq_cla.sv
// BIT-wide carry-lookahead adder shared by every word of a multi-word
// operation; generate/propagate form, carries resolved combinationally.
module carry_lookahead_adder #(
    parameter int BIT = 32
) (
    input  logic [BIT-1:0] i_a,
    input  logic [BIT-1:0] i_b,
    input  logic           i_c,
    output logic [BIT-1:0] o_s,
    output logic           o_c
);

    logic [BIT-1:0] gen;
    logic [BIT-1:0] prop;
    logic [BIT:0]   carry;

    assign gen  = i_a & i_b;
    assign prop = i_a ^ i_b;

    always_comb begin
        carry    = '0;
        carry[0] = i_c;
        for (int i = 0; i < BIT; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign o_s = prop ^ carry[BIT-1:0];
    assign o_c = carry[BIT];

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract sequencer: one narrow CLA walks the operands
// least-significant word first, chaining the carry through a register.
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int BIT   = 32,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WORDS*BIT-1:0]  i_data_a,
    input  logic [WORDS*BIT-1:0]  i_data_b,
    input  logic                  i_carry,
    input  logic                  i_sub,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WORDS*BIT-1:0]  o_data_s,
    output logic                  o_carry
);

    localparam int             IW   = idx_width(WORDS);
    localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

    state_t                     state;
    logic [WORDS-1:0][BIT-1:0]  a_q;
    logic [WORDS-1:0][BIT-1:0]  b_q;
    logic [WORDS-1:0][BIT-1:0]  sum_q;
    logic                       c_q;
    logic [IW-1:0]              idx;

    logic [BIT-1:0]             a_word;
    logic [BIT-1:0]             b_word;
    logic [BIT-1:0]             add_s;
    logic                       add_c;

    // Compare-based word select keeps the mux legal for any WORDS, including 1.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) begin
                a_word = a_q[w];
                b_word = b_q[w];
            end
        end
    end

    carry_lookahead_adder #(.BIT(BIT)) u_cla (
        .i_a (a_word),
        .i_b (b_word),
        .i_c (c_q),
        .o_s (add_s),
        .o_c (add_c)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            idx     <= '0;
            o_carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        // Subtraction is A + ~B + 1, so B is inverted on entry.
                        a_q     <= i_data_a;
                        b_q     <= i_sub ? ~i_data_b : i_data_b;
                        c_q     <= i_sub ? 1'b1 : i_carry;
                        idx     <= '0;
                        state   <= RUN;
                        o_ready <= 1'b0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IW'(w)) begin
                            sum_q[w] <= add_s;
                        end
                    end
                    c_q <= add_c;
                    if (idx == LAST) begin
                        o_carry <= add_c;
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_data_s = sum_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq: directed vectors, handshake and
// reset corner cases, and random traffic on a 4-word and a 1-word instance.
module tb_cla_multiword_seq;

    localparam int BIT = 32;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         cin;
        logic         sub;
        logic [127:0] s;
        logic         c;
    } vec_t;

    logic         i_clk = 1'b0;
    logic         i_rstn;
    logic [127:0] data_a;
    logic [127:0] data_b;
    logic         carry_in;
    logic         sub_in;

    logic         valid0, ready0, o_ready0, o_valid0, o_carry0;
    logic [127:0] o_sum0;
    logic         valid1, ready1, o_ready1, o_valid1, o_carry1;
    logic [31:0]  o_sum1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_accept;

    vec_t vecs[8];

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycle <= cycle + 1;

    cla_multiword_seq #(.BIT(BIT), .WORDS(4)) dut4 (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_valid  (valid0),
        .o_ready  (o_ready0),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_carry  (carry_in),
        .i_sub    (sub_in),
        .o_valid  (o_valid0),
        .i_ready  (ready0),
        .o_data_s (o_sum0),
        .o_carry  (o_carry0)
    );

    cla_multiword_seq #(.BIT(BIT), .WORDS(1)) dut1 (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_valid  (valid1),
        .o_ready  (o_ready1),
        .i_data_a (data_a[31:0]),
        .i_data_b (data_b[31:0]),
        .i_carry  (carry_in),
        .i_sub    (sub_in),
        .o_valid  (o_valid1),
        .i_ready  (ready1),
        .o_data_s (o_sum1),
        .o_carry  (o_carry1)
    );

    // Reference: plain modular arithmetic; subtraction carry means A >= B.
    function automatic logic [128:0] ref_model(input logic [127:0] a, input logic [127:0] b,
                                               input logic cin, input logic sub, input int w);
        logic [128:0] mask, ea, eb, r;
        mask = (w == 128) ? {1'b0, {128{1'b1}}} : ((129'd1 << w) - 129'd1);
        ea   = {1'b0, a} & mask;
        eb   = {1'b0, b} & mask;
        if (sub) begin
            r    = (ea - eb) & mask;
            r[w] = (ea >= eb);
        end else begin
            r = ea + eb + {128'd0, cin};
        end
        return r;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? o_ready1 : o_ready0;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel != 0) ? o_valid1 : o_valid0;
    endfunction

    function automatic logic [128:0] get_result(input int sel);
        return (sel != 0) ? {96'd0, o_carry1, o_sum1} : {o_carry0, o_sum0};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) valid1 = v;
        else          valid0 = v;
    endtask

    task automatic set_ready(input int sel, input logic v);
        if (sel != 0) ready1 = v;
        else          ready0 = v;
    endtask

    task automatic compare(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [127:0] a, input logic [127:0] b,
                                 input logic cin, input logic sub);
        int n;
        n = 0;
        while (!get_ready(sel) && n < 50) begin
            tick();
            n++;
        end
        if (!get_ready(sel)) compare("ready_timeout", 129'd0, 129'd1);
        data_a   = a;
        data_b   = b;
        carry_in = cin;
        sub_in   = sub;
        set_valid(sel, 1'b1);
        tick();
        last_accept = cycle;
        set_valid(sel, 1'b0);
    endtask

    task automatic checkOutput(input int sel, input logic [128:0] exp, input string name,
                               input logic release_result);
        int n;
        n = 0;
        while (!get_valid(sel) && n < 20) begin
            tick();
            n++;
        end
        compare({name, "_latency"}, 129'(n), (sel != 0) ? 129'd1 : 129'd4);
        compare(name, get_result(sel), exp);
        if (release_result) begin
            set_ready(sel, 1'b1);
            tick();
            set_ready(sel, 1'b0);
        end
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [128:0] held;
        logic [128:0] exp;
        logic [127:0] ra, rb;
        logic         rc, rs;
        logic         seen_valid;
        int           prev;

        vecs[0] = '{{128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1};
        vecs[1] = '{128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1};
        vecs[2] = '{128'd5, 128'd7, 1'b1, 1'b1, {{124{1'b1}}, 4'hE}, 1'b0};
        vecs[3] = '{128'd3, 128'd4, 1'b1, 1'b0, 128'd8, 1'b0};
        vecs[4] = '{{64'd0, {64{1'b1}}}, 128'd1, 1'b0, 1'b0, {64'd1, 64'd0}, 1'b0};
        vecs[5] = '{128'd0, 128'd0, 1'b0, 1'b1, 128'd0, 1'b1};
        vecs[6] = '{{128{1'b1}}, {128{1'b1}}, 1'b1, 1'b0, {128{1'b1}}, 1'b1};
        vecs[7] = '{{32'h8000_0000, 96'd0}, {32'h8000_0000, 96'd0}, 1'b0, 1'b0, 128'd0, 1'b1};

        i_rstn   = 1'b0;
        data_a   = '0;
        data_b   = '0;
        carry_in = 1'b0;
        sub_in   = 1'b0;
        valid0   = 1'b0;
        ready0   = 1'b0;
        valid1   = 1'b0;
        ready1   = 1'b0;
        last_accept = -1;

        $display("[TB] reset checks");
        repeat (3) tick();
        compare("rst_ready", 129'(o_ready0), 129'd1);
        compare("rst_valid", 129'(o_valid0), 129'd0);
        compare("rst_result", get_result(0), 129'd0);
        compare("rst_ready_w1", 129'(o_ready1), 129'd1);
        i_rstn = 1'b1;
        tick();

        data_a = 128'd9;
        data_b = 128'd9;
        valid0 = 1'b1;
        i_rstn = 1'b0;
        tick();
        valid0 = 1'b0;
        i_rstn = 1'b1;
        seen_valid = 1'b0;
        compare("idle_rst_ready", 129'(o_ready0), 129'd1);
        repeat (6) begin
            tick();
            seen_valid = seen_valid | o_valid0;
        end
        compare("idle_rst_no_accept", 129'(seen_valid), 129'd0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            checkOutput(0, {vecs[i].c, vecs[i].s}, $sformatf("vec%0d", i), 1'b1);
        end

        $display("[TB] backpressure");
        applyStimulus(0, 128'd100, 128'd23, 1'b0, 1'b0);
        checkOutput(0, 129'd123, "bp_result", 1'b0);
        held = get_result(0);
        for (int k = 0; k < 10; k++) begin
            data_a = {4{$urandom}};
            data_b = {4{$urandom}};
            valid0 = 1'b1;
            tick();
            compare($sformatf("bp_hold%0d", k), {o_valid0, o_ready0, get_result(0)},
                    {1'b1, 1'b0, 129'd123});
        end
        data_a   = 128'd50;
        data_b   = 128'd60;
        carry_in = 1'b0;
        sub_in   = 1'b0;
        ready0   = 1'b1;
        tick();
        ready0   = 1'b0;
        compare("bp_release_state", 129'({o_ready0, o_valid0}), 129'd2);
        compare("bp_release_keep", get_result(0), held);
        tick();
        valid0 = 1'b0;
        checkOutput(0, 129'd110, "bp_next", 1'b1);

        $display("[TB] reset during run");
        applyStimulus(0, {128{1'b1}}, {128{1'b1}}, 1'b1, 1'b0);
        tick();
        tick();
        i_rstn = 1'b0;
        #1;
        compare("runrst_result", get_result(0), 129'd0);
        compare("runrst_hs", 129'({o_ready0, o_valid0}), 129'd2);
        tick();
        i_rstn = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            tick();
            seen_valid = seen_valid | o_valid0;
        end
        compare("runrst_no_valid", 129'(seen_valid), 129'd0);
        applyStimulus(0, 128'd3, 128'd4, 1'b1, 1'b0);
        checkOutput(0, 129'd8, "runrst_next", 1'b1);

        $display("[TB] random traffic");
        for (int sel = 0; sel < 2; sel++) begin
            set_ready(sel, 1'b1);
            prev = -1;
            for (int i = 0; i < 1000; i++) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 7) == 0) rb = ra;
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                exp = ref_model(ra, rb, rc, rs, (sel != 0) ? 32 : 128);
                applyStimulus(sel, ra, rb, rc, rs);
                if (prev >= 0) begin
                    compare($sformatf("rand_period_w%0d", sel), 129'(last_accept - prev),
                            (sel != 0) ? 129'd3 : 129'd6);
                end
                prev = last_accept;
                checkOutput(sel, exp, $sformatf("rand_w%0d_%0d", sel, i), 1'b0);
            end
            tick();
            set_ready(sel, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_multiword_seq.md
# cla_multiword_seq

Multi-precision add/subtract sequencer built around one `carry_lookahead_adder` instance. It accepts one operand pair of `WORDS*BIT` bits over a valid/ready handshake. It then drives the adder one `BIT`-wide word per cycle, least-significant word first, and chains the carry through a register. The full-width sum and carry-out are returned on a second valid/ready handshake. This lets wide arithmetic (128-bit and up) reuse a single narrow adder instead of instantiating a wide one.

## Interface
Parameters:
- `BIT`, default 32: width of the shared CLA and of one operand word.
- `WORDS`, default 4, must be ≥1: number of words per operand. Operand width is `WORDS*BIT`.

Ports:
- `i_clk`, in, 1: clock. Single clock domain; everything is rising-edge.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: operand request valid.
- `o_ready`, out, 1: block can accept a request. High exactly in state IDLE.
- `i_data_a`, in, `WORDS*BIT`: operand A.
- `i_data_b`, in, `WORDS*BIT`: operand B.
- `i_carry`, in, 1: carry-in. Ignored when `i_sub`=1.
- `i_sub`, in, 1: 1 selects A−B, 0 selects A+B+`i_carry`.
- `o_valid`, out, 1: result valid. High exactly in state DONE.
- `i_ready`, in, 1: consumer accepts the result.
- `o_data_s`, out, `WORDS*BIT`: result.
- `o_carry`, out, 1: carry-out of the top word. For subtraction, 1 means no borrow (A≥B).

## Operation
- FSM states are IDLE, RUN, and DONE. The reset state is IDLE.
- **IDLE:**
  - On a rising edge with `i_valid`&&`o_ready`, register the operands into the work registers.
  - Operand A is stored into `a_q`.
  - Operand B is stored into `b_q`: the stored value is `i_data_b` when `i_sub`=0, or `~i_data_b` when `i_sub`=1.
  - The carry register `c_q` is loaded with `i_sub ? 1 : i_carry`.
  - Clear the word index `idx` to 0 and go to RUN.
  - With `i_valid` low, stay in IDLE.
- **RUN:**
  - The adder is driven combinationally with word `idx` of `a_q` and `b_q`, and with `c_q` as carry-in.
  - Each edge, the adder sum is written into word `idx` of `o_data_s` and the adder carry into `c_q`.
  - If `idx`==`WORDS-1`: load `o_carry` from the adder carry and go to DONE. Otherwise increment `idx`.
- **DONE:**
  - `o_data_s` and `o_carry` are stable.
  - On an edge with `i_ready`=1, go to IDLE.
  - With `i_ready` low, hold indefinitely.
- Width of `idx` is `max(1,$clog2(WORDS))`; `idx` never exceeds `WORDS-1`.
- Arithmetic is modulo 2^(`WORDS*BIT`). `o_carry` is the true bit `WORDS*BIT` of A + B' + cin, where B' is `b_q` as stored.
- `i_valid` is ignored outside IDLE (`o_ready`=0). Operand inputs are sampled only on the accept edge.
- After DONE→IDLE, `o_data_s` and `o_carry` keep their last value until words are overwritten in the next RUN.

## Timing
- Reset values: state=IDLE, `o_ready`=1, `o_valid`=0, `o_data_s`=0, `o_carry`=0, `idx`=0, `c_q`=0, `a_q`=0, `b_q`=0.
- Latency:
  - The request is accepted at edge E0.
  - Words 0..WORDS−1 are computed at edges E1..E_WORDS.
  - `o_valid` rises in the cycle after E_WORDS, i.e. WORDS cycles after accept.
- Throughput: with `i_ready` tied high, the minimum period is WORDS+2 cycles (RUN ×WORDS, DONE ×1, IDLE ×1).
- `WORDS`=1: RUN lasts one cycle; behaviour is otherwise identical.
- Reset asserted in any state:
  - All registers return to their reset values immediately (asynchronous).
  - The in-flight operation is discarded and `o_valid` is never raised for it.
- Reset release: the first accept can occur on the first rising edge with `i_rstn`=1.
- Critical path: one `BIT`-wide CLA plus a word-select mux. No `WORDS*BIT`-wide carry path exists.

## Structure
- Package `cla_seq_pkg` holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a width function for `idx`.
- Exactly one sub-module: `carry_lookahead_adder`, parameterised with `.BIT(BIT)`.
- FSM, word mux, and result-write demux live in the top module. There are no additional sub-modules.

## Test plan
Benches use `BIT`=32, `WORDS`=4 unless noted.
1. Reset: hold `i_rstn`=0 for 3 cycles → `o_ready`=1, `o_valid`=0, `o_data_s`=0, `o_carry`=0. Assert reset mid-IDLE with `i_valid`=1 → no accept occurs.
2. Full ripple: A=2^128−1, B=1, `i_carry`=0, `i_sub`=0 → `o_data_s`=0, `o_carry`=1, with `o_valid` exactly 4 cycles after the accept edge.
3. Subtraction:
   - A=7, B=5, `i_sub`=1 → `o_data_s`=2, `o_carry`=1.
   - A=5, B=7, `i_sub`=1 → `o_data_s`=2^128−2, `o_carry`=0.
   - `i_carry`=1 is applied in both cases and has no effect.
4. Backpressure:
   - Hold `i_ready`=0 for 10 cycles in DONE → `o_valid`, `o_data_s`, and `o_carry` stay stable, and `o_ready`=0.
   - A new `i_valid` is ignored until after the DONE→IDLE edge.
5. Reset mid-RUN: deassert `i_rstn` after 2 words are computed → outputs return to reset values and no `o_valid` is raised. The next request, A=3, B=4, `i_carry`=1, gives 8, `o_carry`=0.
6. Random test:
   - Run 1000 back-to-back random A, B, `i_carry`, `i_sub` with `i_ready` tied high.
   - Check {`o_carry`,`o_data_s`} against a behavioural reference (A+B+cin, or A+~B+1).
   - Check a period of 6 cycles.
   - Repeat the test with `WORDS`=1.
